note_recorder: RTL and testbench
================================

NOTE_RECORDER -- requirements
Module: note_recorder

Interface
REQ-001 Parameter DEPTH, 16, number of stored note entries (power of two).
REQ-002 Parameter DUR_W, 8, width of per-entry duration field in ticks.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 n_rst  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  block enable; low forces IDLE and silences output.
REQ-006 keypad_i  input  15  raw note pushbuttons (live play).
REQ-007 rec_btn  input  1  record start/stop button (level).
REQ-008 play_btn  input  1  playback start/stop button (level).
REQ-009 loop  input  1  high: playback restarts at entry 0 after the last entry.
REQ-010 tick  input  1  one-cycle 8 Hz time-base strobe.
REQ-011 keypad_o  output  15  registered note vector to the synth keypad encoder.
REQ-012 state_o  output  2  00 IDLE, 01 RECORD, 10 PLAY.
REQ-013 count_o  output  log2(DEPTH)+1  number of valid stored entries.
REQ-014 full_o  output  1  high when count_o == DEPTH.

Function
REQ-015 rec_btn and play_btn SHALL be edge-detected internally: edge = current & ~previous-cycle value; the previous-value flops reset to 0.
REQ-016 Each stored entry SHALL be {pattern[14:0], dur[DUR_W-1:0]}; silence is stored as pattern 0.
REQ-017 IDLE: keypad_o SHALL equal keypad_i delayed one clk.
REQ-018 IDLE + rec edge: SHALL go to RECORD, clear count_o and full_o to 0, latch cur_pat = keypad_i, cur_dur = 0.
REQ-019 IDLE + play edge: SHALL go to PLAY at entry 0 if count_o > 0; else SHALL stay IDLE.
REQ-020 IDLE with rec and play edges in the same cycle: rec SHALL win.
REQ-021 RECORD: keypad_o SHALL pass keypad_i delayed one clk, exactly as in IDLE.
REQ-022 RECORD: each tick SHALL increment cur_dur, saturating at 2^DUR_W-1.
REQ-023 RECORD: keypad_i != cur_pat SHALL write {cur_pat, cur_dur} at index count_o, increment count_o, then set cur_pat = keypad_i and cur_dur = 0.
REQ-024 RECORD: a pattern change and a tick in the same cycle SHALL store cur_dur+1 (saturated); the new note's duration starts at 0.
REQ-025 RECORD + rec edge: SHALL write the final {cur_pat, cur_dur} entry and go to IDLE; this write counts toward count_o.
REQ-026 RECORD: a write that makes count_o == DEPTH SHALL set full_o and go to IDLE in the same cycle; no further writes occur.
REQ-027 RECORD: play edges SHALL be ignored.
REQ-028 PLAY: keypad_o SHALL equal the pattern of the current entry, registered.
REQ-029 PLAY: entry timing SHALL use remaining = max(dur,1), loaded on entry start and decremented on each tick.
REQ-030 PLAY: when remaining reaches 0, SHALL advance to the next entry in the same cycle.
REQ-031 PLAY: after the last entry (index count_o-1), SHALL restart at entry 0 if loop = 1; else SHALL go to IDLE.
REQ-032 PLAY + play edge: SHALL go to IDLE; keypad_o reverts to the delayed keypad_i on the following clk.
REQ-033 PLAY: rec edges SHALL be ignored.
REQ-034 en = 0: state SHALL go to IDLE on the next clk and keypad_o SHALL be 0.
REQ-035 en = 0: stored entries and count_o SHALL be preserved; edges and ticks SHALL be ignored.
REQ-036 Memory SHALL be a register array written only in RECORD; it SHALL NOT be reset.

Reset
REQ-037 n_rst = 0 at a clk edge SHALL set state IDLE, keypad_o 0, count_o 0, full_o 0, all pointers, durations and edge flops 0, in any state, including mid-RECORD or mid-PLAY.
REQ-038 After reset, a play edge SHALL leave the block in IDLE because count_o = 0.

Verification
REQ-039 Record: rec edge; hold bit0 for 3 ticks, bit5 for 2 ticks, 0 for 1 tick; rec edge -> count_o = 3; entries {0x0001,3}, {0x0020,2}, {0x0000,1}.
REQ-040 Playback of REQ-039 data, loop = 0: play edge -> keypad_o 0x0001 for 3 ticks, 0x0020 for 2, 0x0000 for 1, then IDLE.
REQ-041 Loop playback and stop: loop = 1 -> sequence repeats from entry 0; play edge mid-entry -> IDLE; keypad_o tracks keypad_i one clk later.
REQ-042 Full: 16 pattern changes in RECORD -> full_o = 1, state IDLE on the 16th write; a 17th change is not stored.
REQ-043 Saturation and simultaneity: hold one note for 300 ticks -> stored dur 255; rec and play edges in the same cycle from IDLE -> RECORD.
REQ-044 Reset mid-PLAY -> next cycle IDLE, keypad_o 0, count_o 0; en = 0 mid-RECORD -> IDLE, count_o preserved.

Source files
------------

// File: rtl/note_recorder.sv
// Note recorder/player sitting between the raw keypad and the synth keypad encoder.
// Records {pattern, duration} entries on 8 Hz ticks and plays them back.
module note_recorder #(
    parameter int DEPTH = 16,
    parameter int DUR_W = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     en,
    input  logic [14:0]              keypad_i,
    input  logic                     rec_btn,
    input  logic                     play_btn,
    input  logic                     loop,
    input  logic                     tick,
    output logic [14:0]              keypad_o,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_W   = AW + 1;
    localparam int ENTRY_W = 15 + DUR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        PLAY   = 2'b10
    } state_t;

    function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] d);
        return (&d) ? d : d + 1'b1;
    endfunction

    // A zero-length entry still plays for one tick.
    function automatic logic [DUR_W-1:0] min_one(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    state_t               state, state_next;
    logic                 rec_prev, play_prev;
    logic [CNT_W-1:0]     count, count_next;
    logic [14:0]          cur_pat, cur_pat_next;
    logic [DUR_W-1:0]     cur_dur, cur_dur_next;
    logic [AW-1:0]        play_idx, play_idx_next;
    logic [DUR_W-1:0]     remaining, remaining_next;
    logic [14:0]          keypad_next;
    logic                 wr_en;
    logic [ENTRY_W-1:0]   wr_data;
    logic [ENTRY_W-1:0]   mem [DEPTH];

    logic                 rec_edge, play_edge, tick_en;
    logic                 pat_change, rec_write, entry_end, last_entry;
    logic [DUR_W-1:0]     dur_now;
    logic [CNT_W-1:0]     count_inc;
    logic [AW-1:0]        idx_inc;

    assign rec_edge   = en & rec_btn & ~rec_prev;
    assign play_edge  = en & play_btn & ~play_prev;
    assign tick_en    = en & tick;
    assign pat_change = (keypad_i != cur_pat);
    assign dur_now    = tick_en ? sat_inc(cur_dur) : cur_dur;
    assign rec_write  = en && (state == RECORD) && (pat_change || rec_edge);
    assign count_inc  = count + 1'b1;
    assign idx_inc    = play_idx + 1'b1;
    assign last_entry = ({1'b0, play_idx} == (count - 1'b1));
    assign entry_end  = (state == PLAY) && tick_en && (remaining == DUR_W'(1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rec_edge) begin
                        state_next = RECORD;
                    end else if (play_edge && (count != '0)) begin
                        state_next = PLAY;
                    end
                end
                RECORD: begin
                    if (rec_write && (rec_edge || (count_inc == CNT_W'(DEPTH)))) begin
                        state_next = IDLE;
                    end
                end
                PLAY: begin
                    if (play_edge) begin
                        state_next = IDLE;
                    end else if (entry_end && last_entry && !loop) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        count_next     = count;
        cur_pat_next   = cur_pat;
        cur_dur_next   = cur_dur;
        play_idx_next  = play_idx;
        remaining_next = remaining;
        wr_en          = 1'b0;
        wr_data        = {cur_pat, dur_now};
        keypad_next    = '0;
        if (en) begin
            keypad_next = (state == PLAY) ? mem[play_idx][ENTRY_W-1 -: 15] : keypad_i;
            case (state)
                IDLE: begin
                    if (rec_edge) begin
                        count_next   = '0;
                        cur_pat_next = keypad_i;
                        cur_dur_next = '0;
                    end else if (play_edge && (count != '0)) begin
                        play_idx_next  = '0;
                        remaining_next = min_one(mem[0][DUR_W-1:0]);
                    end
                end
                RECORD: begin
                    cur_dur_next = dur_now;
                    if (rec_write) begin
                        wr_en        = 1'b1;
                        count_next   = count_inc;
                        cur_pat_next = keypad_i;
                        cur_dur_next = '0;
                    end
                end
                PLAY: begin
                    if (!play_edge && tick_en) begin
                        if (remaining == DUR_W'(1)) begin
                            if (!last_entry) begin
                                play_idx_next  = idx_inc;
                                remaining_next = min_one(mem[idx_inc][DUR_W-1:0]);
                            end else if (loop) begin
                                play_idx_next  = '0;
                                remaining_next = min_one(mem[0][DUR_W-1:0]);
                            end
                        end else begin
                            remaining_next = remaining - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Edge flops sample every cycle so a button held through en=0 never fires late.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rec_prev  <= 1'b0;
            play_prev <= 1'b0;
            count     <= '0;
            cur_pat   <= '0;
            cur_dur   <= '0;
            play_idx  <= '0;
            remaining <= '0;
            keypad_o  <= '0;
        end else begin
            rec_prev  <= rec_btn;
            play_prev <= play_btn;
            count     <= count_next;
            cur_pat   <= cur_pat_next;
            cur_dur   <= cur_dur_next;
            play_idx  <= play_idx_next;
            remaining <= remaining_next;
            keypad_o  <= keypad_next;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst && wr_en) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    assign state_o = state;
    assign count_o = count;
    assign full_o  = (count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder: record, playback, loop, full, saturation, reset and enable.
module tb_note_recorder;

    logic        clk = 1'b0;
    logic        n_rst, en, rec_btn, play_btn, loop, tick;
    logic [14:0] keypad_i;
    logic [14:0] keypad_o;
    logic [1:0]  state_o;
    logic [4:0]  count_o;
    logic        full_o;

    int tests = 0;
    int fails = 0;

    note_recorder #(.DEPTH(16), .DUR_W(8)) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .keypad_i(keypad_i),
        .rec_btn(rec_btn), .play_btn(play_btn), .loop(loop), .tick(tick),
        .keypad_o(keypad_o), .state_o(state_o), .count_o(count_o), .full_o(full_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic press_rec();
        rec_btn = 1'b1;
        step();
        rec_btn = 1'b0;
        step();
    endtask

    task automatic press_play();
        play_btn = 1'b1;
        step();
        play_btn = 1'b0;
        step();
    endtask

    initial begin
        n_rst = 1'b0; en = 1'b1; rec_btn = 1'b0; play_btn = 1'b0;
        loop = 1'b0; tick = 1'b0; keypad_i = 15'h7FFF;
        step();
        step();
        chk("rst_state", state_o, 2'b00);
        chk("rst_count", count_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_keypad", keypad_o, 0);
        n_rst = 1'b1;

        press_play();
        chk("play_empty_idle", state_o, 2'b00);
        keypad_i = 15'h1234;
        step();
        chk("idle_passthru", keypad_o, 15'h1234);

        // Record 0x0001 x3, 0x0020 x2, silence x1
        keypad_i = 15'h0001;
        press_rec();
        chk("rec_enter", state_o, 2'b01);
        chk("rec_count0", count_o, 0);
        chk("rec_passthru", keypad_o, 15'h0001);
        repeat (3) do_tick();
        keypad_i = 15'h0020;
        step();
        chk("rec_count1", count_o, 1);
        repeat (2) do_tick();
        keypad_i = 15'h0000;
        step();
        chk("rec_count2", count_o, 2);
        do_tick();
        press_rec();
        chk("rec_stop_count", count_o, 3);
        chk("rec_stop_state", state_o, 2'b00);
        chk("rec_stop_full", full_o, 0);

        // Playback, no loop
        press_play();
        chk("play_state", state_o, 2'b10);
        chk("play_e0", keypad_o, 15'h0001);
        keypad_i = 15'h7000;
        do_tick();
        chk("play_e0_t1", keypad_o, 15'h0001);
        do_tick();
        chk("play_e0_t2", keypad_o, 15'h0001);
        do_tick();
        chk("play_e1", keypad_o, 15'h0020);
        do_tick();
        chk("play_e1_t1", keypad_o, 15'h0020);
        do_tick();
        chk("play_e2", keypad_o, 15'h0000);
        chk("play_e2_state", state_o, 2'b10);
        do_tick();
        chk("play_end_state", state_o, 2'b00);
        chk("play_end_passthru", keypad_o, 15'h7000);

        // Loop playback, then stop mid-entry
        loop = 1'b1;
        press_play();
        chk("loop_e0", keypad_o, 15'h0001);
        repeat (6) do_tick();
        chk("loop_wrap_state", state_o, 2'b10);
        chk("loop_wrap_e0", keypad_o, 15'h0001);
        do_tick();
        play_btn = 1'b1;
        step();
        chk("stop_state", state_o, 2'b00);
        chk("stop_keypad_hold", keypad_o, 15'h0001);
        play_btn = 1'b0;
        keypad_i = 15'h0555;
        step();
        chk("stop_passthru", keypad_o, 15'h0555);
        loop = 1'b0;

        press_play();
        press_rec();
        chk("play_rec_ignored", state_o, 2'b10);
        chk("play_rec_count", count_o, 3);
        press_play();
        chk("play_stop2", state_o, 2'b00);

        // Fill all 16 entries
        keypad_i = 15'h0100;
        press_rec();
        press_play();
        chk("rec_play_ignored", state_o, 2'b01);
        for (int i = 1; i <= 16; i++) begin
            keypad_i = 15'(i);
            step();
            if (i == 15) begin
                chk("full_15_state", state_o, 2'b01);
                chk("full_15_flag", full_o, 0);
            end
        end
        chk("full_count", count_o, 16);
        chk("full_flag", full_o, 1);
        chk("full_state", state_o, 2'b00);
        keypad_i = 15'd17;
        step();
        chk("full_17th", count_o, 16);
        press_play();
        chk("full_play_e0", keypad_o, 15'h0100);
        do_tick();
        chk("full_play_e1", keypad_o, 15'h0001);
        press_play();

        // Duration saturation
        keypad_i = 15'h0004;
        press_rec();
        chk("sat_full_clr", full_o, 0);
        chk("sat_count_clr", count_o, 0);
        repeat (300) do_tick();
        press_rec();
        chk("sat_count", count_o, 1);
        press_play();
        chk("sat_play", keypad_o, 15'h0004);
        repeat (254) do_tick();
        chk("sat_254", state_o, 2'b10);
        do_tick();
        chk("sat_255", state_o, 2'b00);

        // Simultaneous rec and play edges: rec wins
        rec_btn = 1'b1;
        play_btn = 1'b1;
        step();
        chk("simul_state", state_o, 2'b01);
        chk("simul_count", count_o, 0);
        rec_btn = 1'b0;
        play_btn = 1'b0;
        step();

        // en=0 mid-RECORD keeps the stored entries
        do_tick();
        keypad_i = 15'h0008;
        step();
        keypad_i = 15'h0009;
        step();
        chk("en_pre_count", count_o, 2);
        en = 1'b0;
        step();
        chk("en_off_state", state_o, 2'b00);
        chk("en_off_keypad", keypad_o, 0);
        chk("en_off_count", count_o, 2);
        press_rec();
        chk("en_off_rec_ignored", state_o, 2'b00);
        en = 1'b1;
        step();
        chk("en_on_passthru", keypad_o, 15'h0009);

        // Reset mid-PLAY
        press_play();
        chk("rst_pre_play", state_o, 2'b10);
        n_rst = 1'b0;
        step();
        chk("rst_play_state", state_o, 2'b00);
        chk("rst_play_keypad", keypad_o, 0);
        chk("rst_play_count", count_o, 0);
        n_rst = 1'b1;
        step();
        press_play();
        chk("rst_play_empty", state_o, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
